obstacle_spawner: RTL and testbench
===================================

Name: obstacle_spawner

Overview:
Parametrised multi-slot obstacle engine for the dino runner. It manages NUM_OBS independent obstacle slots scrolling right-to-left. Spawn spacing and obstacle type are pseudo-random from an internal LFSR, and scroll velocity ramps up over game time. It sits between the game-tick generator and the renderer/collision logic, and exposes packed slot positions, types and active flags.

Parameters:
NUM_OBS, 3, number of obstacle slots (1..8)
X_WIDTH, 10, width of each x position
SPAWN_X, 640, x loaded into a slot on spawn/despawn (< 2^X_WIDTH)
MIN_GAP, 160, minimum scroll distance between consecutive spawns
GAP_RANGE_BITS, 7, random extra gap 0..2^GAP_RANGE_BITS-1 added to MIN_GAP
VEL_INIT, 4, velocity after reset (px/tick)
VEL_MAX, 12, velocity saturation value (VEL_MAX < MIN_GAP)
RAMP_TICKS, 256, qualified ticks per velocity increment (>= 1)
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  game running; when low, all state holds
freeze  in  1  collision/pause; when high, all state holds
game_tick  in  1  one-cycle frame pulse
obstacle_x  out  NUM_OBS*X_WIDTH  slot i x at [i*X_WIDTH +: X_WIDTH]
obstacle_active  out  NUM_OBS  slot i valid for draw/collision
obstacle_type  out  2*NUM_OBS  slot i type at [2i +: 2] (0 small cactus, 1 large cactus, 2 cactus pair, 3 bird)
velocity  out  4  current scroll velocity
passed_count  out  4  number of slots despawned on the last qualified tick; 0 otherwise

Behaviour:
- Reset is asynchronous on posedge rst and ignores the clock. Values during and after reset:
  - all obstacle_active = 0, every obstacle_x = SPAWN_X, every type = 0
  - velocity = VEL_INIT, gap_cnt = MIN_GAP, ramp_cnt = 0, LFSR = seed, passed_count = 0
- Qualified tick: game_tick & enable & ~freeze. All state changes happen only on a qualified tick. All outputs are registered and show the update one cycle after the tick.
- passed_count is cleared on every cycle that is not a qualified tick (1-cycle pulse).
- LFSR: 16-bit Galois, mask 16'hB400, shifts once per qualified tick. Draws use the pre-shift value.
- Per-slot motion (active slots, pre-tick state):
  - if x <= velocity: active <= 0, x <= SPAWN_X, counted into passed_count
  - else: x <= x - velocity
  - Inactive slots hold.
- Spawn counter gap_cnt has width X_WIDTH+1.
  - If gap_cnt > velocity: gap_cnt <= gap_cnt - velocity.
  - Else a spawn is requested. Target is the lowest-index slot that is inactive in the pre-tick active vector.
  - Spawn: active <= 1, x <= SPAWN_X, type <= LFSR[1:0], gap_cnt <= MIN_GAP + LFSR[GAP_RANGE_BITS+1:2].
  - A spawned slot does not move on its spawn tick.
  - No free slot: the spawn is deferred and gap_cnt <= 0, retried on every subsequent qualified tick.
  - A slot freed on the same tick is not eligible until the next tick.
- Velocity ramp:
  - ramp_cnt increments per qualified tick.
  - At RAMP_TICKS-1 it wraps to 0 and velocity <= min(velocity+1, VEL_MAX).
  - The new velocity applies from the following tick.
- Simultaneous despawn and spawn on different slots in one tick are both performed.
- A reset mid-run discards all slots immediately; there is no partial state.
- Parameter checks are elaboration-time:
  - SPAWN_X < 2^X_WIDTH
  - MIN_GAP + 2^GAP_RANGE_BITS - 1 < 2^(X_WIDTH+1)
  - VEL_MAX <= 15

Test Plan:
1. Reset/hold: assert rst mid-cycle -> outputs clear asynchronously to the reset values (active=0, x=640, velocity=4). With enable=0, 50 game_ticks -> nothing changes.
2. First spawn (defaults, RAMP_TICKS=1000): qualified ticks 1..39 take gap_cnt 160->4 -> tick 40 sets slot0 active, x=640, type=LFSR[1:0] of the pre-shift value. Check against the bench LFSR model.
3. Despawn: slot spawned on tick T -> x=640-4k after tick T+k. At T+159, x=4. At T+160, slot inactive with x=640, and passed_count=1 for exactly one cycle.
4. Slot exhaustion (NUM_OBS=1, MIN_GAP=16): the second spawn request while slot0 is active -> deferred with gap_cnt=0. The spawn occurs on the first tick after slot0's despawn tick, not on the same tick.
5. Ramp saturation (RAMP_TICKS=4, VEL_MAX=6) -> velocity 4 until the 4th tick, then 5, 6 after the 8th tick, and stays at 6 thereafter. Positions decrement by the active velocity.
6. Freeze: freeze=1 for 20 ticks mid-run -> x, gap_cnt, LFSR, ramp_cnt and velocity are unchanged and passed_count=0. Resume continues exactly where it stopped.

Source files
------------

// File: rtl/obstacle_spawner.sv
// Multi-slot obstacle engine for the dino runner: scrolls NUM_OBS slots
// right-to-left, spawns on an LFSR-randomised gap and ramps scroll speed.
module obstacle_spawner #(
    parameter int          NUM_OBS        = 3,
    parameter int          X_WIDTH        = 10,
    parameter int          SPAWN_X        = 640,
    parameter int          MIN_GAP        = 160,
    parameter int          GAP_RANGE_BITS = 7,
    parameter int          VEL_INIT       = 4,
    parameter int          VEL_MAX        = 12,
    parameter int          RAMP_TICKS     = 256,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         freeze,
    input  logic                         game_tick,
    output logic [NUM_OBS*X_WIDTH-1:0]   obstacle_x,
    output logic [NUM_OBS-1:0]           obstacle_active,
    output logic [2*NUM_OBS-1:0]         obstacle_type,
    output logic [3:0]                   velocity,
    output logic [3:0]                   passed_count
);

    localparam int GW = X_WIDTH + 1;
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam logic [X_WIDTH-1:0] SPAWN_XV = X_WIDTH'(SPAWN_X);

    if (SPAWN_X >= (1 << X_WIDTH)) begin : g_chk_spawn
        $error("SPAWN_X does not fit in X_WIDTH");
    end
    if (MIN_GAP + (1 << GAP_RANGE_BITS) - 1 >= (1 << (X_WIDTH + 1))) begin : g_chk_gap
        $error("MIN_GAP plus random range overflows gap counter");
    end
    if (VEL_MAX > 15) begin : g_chk_vel
        $error("VEL_MAX exceeds 4-bit velocity");
    end

    logic [X_WIDTH-1:0] x_q   [NUM_OBS];
    logic [X_WIDTH-1:0] x_d   [NUM_OBS];
    logic [1:0]         typ_q [NUM_OBS];
    logic [1:0]         typ_d [NUM_OBS];
    logic [NUM_OBS-1:0] act_q, act_d;
    logic [NUM_OBS-1:0] free_oh;
    logic [3:0]         vel_q, vel_d;
    logic [3:0]         pass_q, pass_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [RW-1:0]      ramp_q, ramp_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [X_WIDTH-1:0] vel_x;
    logic [GW-1:0]      vel_g;
    logic               tick;
    logic               taken;

    assign tick  = game_tick & enable & ~freeze;
    assign vel_x = X_WIDTH'(vel_q);
    assign vel_g = GW'(vel_q);

    always_comb begin
        x_d     = x_q;
        typ_d   = typ_q;
        act_d   = act_q;
        vel_d   = vel_q;
        gap_d   = gap_q;
        ramp_d  = ramp_q;
        lfsr_d  = lfsr_q;
        pass_d  = '0;
        free_oh = '0;
        taken   = 1'b0;
        // Spawn target comes from the pre-tick vector, so a slot freed
        // this tick is only reusable from the next tick onwards.
        for (int i = 0; i < NUM_OBS; i++) begin
            free_oh[i] = ~act_q[i] & ~taken;
            taken      = taken | ~act_q[i];
        end
        if (tick) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            for (int i = 0; i < NUM_OBS; i++) begin
                if (act_q[i]) begin
                    if (x_q[i] <= vel_x) begin
                        act_d[i] = 1'b0;
                        x_d[i]   = SPAWN_XV;
                        pass_d   = pass_d + 4'd1;
                    end else begin
                        x_d[i] = x_q[i] - vel_x;
                    end
                end
            end
            if (gap_q > vel_g) begin
                gap_d = gap_q - vel_g;
            end else if (|free_oh) begin
                gap_d = GW'(MIN_GAP) + GW'(lfsr_q[GAP_RANGE_BITS+1:2]);
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (free_oh[i]) begin
                        act_d[i] = 1'b1;
                        x_d[i]   = SPAWN_XV;
                        typ_d[i] = lfsr_q[1:0];
                    end
                end
            end else begin
                gap_d = '0;
            end
            if (ramp_q == RW'(RAMP_TICKS - 1)) begin
                ramp_d = '0;
                vel_d  = (vel_q >= 4'(VEL_MAX)) ? 4'(VEL_MAX) : vel_q + 4'd1;
            end else begin
                ramp_d = ramp_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i]   <= SPAWN_XV;
                typ_q[i] <= 2'd0;
            end
            act_q  <= '0;
            vel_q  <= 4'(VEL_INIT);
            pass_q <= '0;
            gap_q  <= GW'(MIN_GAP);
            ramp_q <= '0;
            lfsr_q <= SEED;
        end else begin
            x_q    <= x_d;
            typ_q  <= typ_d;
            act_q  <= act_d;
            vel_q  <= vel_d;
            pass_q <= pass_d;
            gap_q  <= gap_d;
            ramp_q <= ramp_d;
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
        assign obstacle_x[g*X_WIDTH +: X_WIDTH] = x_q[g];
        assign obstacle_type[2*g +: 2]          = typ_q[g];
    end

    assign obstacle_active = act_q;
    assign velocity        = vel_q;
    assign passed_count    = pass_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: three parameterisations driven in lockstep
// and checked against an array-based behavioural model.
module tb_obstacle_spawner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic freeze = 1'b0;
    logic game_tick = 1'b0;

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [29:0] x0, x2;
    logic [9:0]  x1;
    logic [2:0]  a0, a2;
    logic [0:0]  a1;
    logic [5:0]  t0, t2;
    logic [1:0]  t1;
    logic [3:0]  v0, v1, v2, p0, p1, p2;

    obstacle_spawner #(.RAMP_TICKS(1000)) u_d0 (
        .clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
        .game_tick(game_tick), .obstacle_x(x0), .obstacle_active(a0),
        .obstacle_type(t0), .velocity(v0), .passed_count(p0)
    );
    obstacle_spawner #(.NUM_OBS(1), .MIN_GAP(16)) u_d1 (
        .clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
        .game_tick(game_tick), .obstacle_x(x1), .obstacle_active(a1),
        .obstacle_type(t1), .velocity(v1), .passed_count(p1)
    );
    obstacle_spawner #(.RAMP_TICKS(4), .VEL_MAX(6)) u_d2 (
        .clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
        .game_tick(game_tick), .obstacle_x(x2), .obstacle_active(a2),
        .obstacle_type(t2), .velocity(v2), .passed_count(p2)
    );

    logic [79:0]  dx [3];
    logic [7:0]   da [3];
    logic [3:0]   dv [3];
    logic [3:0]   dp [3];
    logic [111:0] dall [3];

    assign dx[0] = 80'(x0);
    assign dx[1] = 80'(x1);
    assign dx[2] = 80'(x2);
    assign da[0] = 8'(a0);
    assign da[1] = 8'(a1);
    assign da[2] = 8'(a2);
    assign dv[0] = v0;
    assign dv[1] = v1;
    assign dv[2] = v2;
    assign dp[0] = p0;
    assign dp[1] = p1;
    assign dp[2] = p2;
    assign dall[0] = {80'(x0), 8'(a0), 16'(t0), v0, p0};
    assign dall[1] = {80'(x1), 8'(a1), 16'(t1), v1, p1};
    assign dall[2] = {80'(x2), 8'(a2), 16'(t2), v2, p2};

    // Per-instance parameters and model state
    int P_N[3]    = '{3, 1, 3};
    int P_MIN[3]  = '{160, 16, 160};
    int P_VMAX[3] = '{12, 12, 6};
    int P_RAMP[3] = '{1000, 256, 4};

    int          mx [3][8];
    bit          ma [3][8];
    int          mt [3][8];
    int          mv [3];
    int          mg [3];
    int          mr [3];
    int          mp [3];
    logic [15:0] ml [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                mx[k][i] = 640;
                ma[k][i] = 1'b0;
                mt[k][i] = 0;
            end
            mv[k] = 4;
            mg[k] = P_MIN[k];
            mr[k] = 0;
            mp[k] = 0;
            ml[k] = 16'hACE1;
        end
    endtask

    task automatic model_tick(input int k);
        bit pre [8];
        int free;
        int passed;
        free = -1;
        passed = 0;
        for (int i = 0; i < P_N[k]; i++) begin
            pre[i] = ma[k][i];
            if (!pre[i] && free < 0) free = i;
        end
        for (int i = 0; i < P_N[k]; i++) begin
            if (pre[i]) begin
                if (mx[k][i] <= mv[k]) begin
                    ma[k][i] = 1'b0;
                    mx[k][i] = 640;
                    passed++;
                end else begin
                    mx[k][i] = mx[k][i] - mv[k];
                end
            end
        end
        if (mg[k] > mv[k]) begin
            mg[k] = mg[k] - mv[k];
        end else if (free >= 0) begin
            ma[k][free] = 1'b1;
            mx[k][free] = 640;
            mt[k][free] = int'(ml[k]) % 4;
            mg[k] = P_MIN[k] + (int'(ml[k]) / 4) % 128;
        end else begin
            mg[k] = 0;
        end
        if (mr[k] == P_RAMP[k] - 1) begin
            mr[k] = 0;
            mv[k] = (mv[k] + 1 > P_VMAX[k]) ? P_VMAX[k] : mv[k] + 1;
        end else begin
            mr[k]++;
        end
        ml[k] = ml[k][0] ? ((ml[k] >> 1) ^ 16'hB400) : (ml[k] >> 1);
        mp[k] = passed;
    endtask

    function automatic logic [111:0] exp_all(input int k);
        logic [79:0] rx;
        logic [7:0]  ra;
        logic [15:0] rt;
        rx = '0;
        ra = '0;
        rt = '0;
        for (int i = 0; i < P_N[k]; i++) begin
            rx[i*10 +: 10] = 10'(mx[k][i]);
            ra[i]          = ma[k][i];
            rt[2*i +: 2]   = 2'(mt[k][i]);
        end
        return {rx, ra, rt, 4'(mv[k]), 4'(mp[k])};
    endfunction

    function automatic logic [15:0] lfsr_n(input int n);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < n; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        return l;
    endfunction

    task automatic step(input bit t, input bit e, input bit f);
        game_tick = t;
        enable = e;
        freeze = f;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (t && e && !f) model_tick(k);
            else mp[k] = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        game_tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (da[k] !== 8'd0 || dv[k] !== 4'd4 || dp[k] !== 4'd0) begin
                tests_failed++;
                $display("FAIL reset_ctl k=%0d act=%h vel=%0d pass=%0d exp 0/4/0",
                         k, da[k], dv[k], dp[k]);
            end
            tests_run++;
            if (dall[k] !== exp_all(k)) begin
                tests_failed++;
                $display("FAIL reset_all k=%0d got %h exp %h", k, dall[k], exp_all(k));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 50; n++) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (dall[k] !== exp_all(k) || da[k] !== 8'd0 || dv[k] !== 4'd4) begin
                tests_failed++;
                $display("FAIL enable_hold k=%0d got %h exp %h", k, dall[k], exp_all(k));
            end
        end
    endtask

    task automatic test_first_spawn();
        logic [15:0] l39;
        do_reset();
        for (int n = 0; n < 39; n++) step(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (da[0] !== 8'd0) begin
            tests_failed++;
            $display("FAIL pre_spawn act=%h exp 00", da[0]);
        end
        step(1'b1, 1'b1, 1'b0);
        l39 = lfsr_n(39);
        tests_run++;
        if (da[0] !== 8'd1 || dx[0][9:0] !== 10'd640 || t0[1:0] !== l39[1:0]) begin
            tests_failed++;
            $display("FAIL first_spawn act=%h x=%0d typ=%0d exp 01/640/%0d",
                     da[0], dx[0][9:0], t0[1:0], l39[1:0]);
        end
        tests_run++;
        if (dall[0] !== exp_all(0)) begin
            tests_failed++;
            $display("FAIL first_spawn_all got %h exp %h", dall[0], exp_all(0));
        end
    endtask

    task automatic test_despawn();
        for (int k = 1; k <= 160; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (k == 1) begin
                tests_run++;
                if (dx[0][9:0] !== 10'd636) begin
                    tests_failed++;
                    $display("FAIL move1 x=%0d exp 636", dx[0][9:0]);
                end
            end
            if (k == 159) begin
                tests_run++;
                if (dx[0][9:0] !== 10'd4 || da[0][0] !== 1'b1 || dp[0] !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL at_edge x=%0d act=%b pass=%0d exp 4/1/0",
                             dx[0][9:0], da[0][0], dp[0]);
                end
            end
            if (k == 160) begin
                tests_run++;
                if (dx[0][9:0] !== 10'd640 || da[0][0] !== 1'b0 || dp[0] !== 4'd1) begin
                    tests_failed++;
                    $display("FAIL despawn x=%0d act=%b pass=%0d exp 640/0/1",
                             dx[0][9:0], da[0][0], dp[0]);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (dp[0] !== 4'd0) begin
            tests_failed++;
            $display("FAIL pass_pulse got %0d exp 0", dp[0]);
        end
        tests_run++;
        if (dall[0] !== exp_all(0)) begin
            tests_failed++;
            $display("FAIL despawn_all got %h exp %h", dall[0], exp_all(0));
        end
    endtask

    task automatic test_exhaustion();
        int n;
        do_reset();
        n = 0;
        while (n < 400) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
            if (n == 4) begin
                tests_run++;
                if (da[1][0] !== 1'b1 || dx[1][9:0] !== 10'd640) begin
                    tests_failed++;
                    $display("FAIL exh_spawn1 act=%b x=%0d exp 1/640", da[1][0], dx[1][9:0]);
                end
            end
            if (dp[1] !== 4'd0) break;
        end
        tests_run++;
        if (n !== 164 || da[1][0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL exh_despawn tick=%0d act=%b exp 164/0", n, da[1][0]);
        end
        step(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (da[1][0] !== 1'b1 || dx[1][9:0] !== 10'd640 || dall[1] !== exp_all(1)) begin
            tests_failed++;
            $display("FAIL exh_respawn act=%b x=%0d got %h exp %h",
                     da[1][0], dx[1][9:0], dall[1], exp_all(1));
        end
    endtask

    task automatic test_ramp();
        int ev;
        do_reset();
        for (int n = 1; n <= 120; n++) begin
            step(1'b1, 1'b1, 1'b0);
            ev = 4 + n / 4;
            if (ev > 6) ev = 6;
            tests_run++;
            if (dv[2] !== 4'(ev)) begin
                tests_failed++;
                $display("FAIL ramp tick=%0d vel=%0d exp %0d", n, dv[2], ev);
            end
            tests_run++;
            if (dall[2] !== exp_all(2)) begin
                tests_failed++;
                $display("FAIL ramp_all tick=%0d got %h exp %h", n, dall[2], exp_all(2));
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int n = 0; n < 150; n++) step(($urandom % 3) != 0, 1'b1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 1'b1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (dall[k] !== exp_all(k) || dp[k] !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL freeze k=%0d got %h exp %h", k, dall[k], exp_all(k));
                end
            end
        end
        for (int n = 0; n < 60; n++) begin
            step(1'b1, 1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (dall[k] !== exp_all(k)) begin
                    tests_failed++;
                    $display("FAIL resume k=%0d got %h exp %h", k, dall[k], exp_all(k));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000 && tests_failed < 30; n++) begin
            step(($urandom % 2) == 0, ($urandom % 8) != 0, ($urandom % 10) == 0);
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (dall[k] !== exp_all(k)) begin
                    tests_failed++;
                    $display("FAIL random n=%0d k=%0d got %h exp %h",
                             n, k, dall[k], exp_all(k));
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (dall[k] !== exp_all(k) || da[k] !== 8'd0 || dv[k] !== 4'd4) begin
                tests_failed++;
                $display("FAIL midrun_reset k=%0d got %h exp %h", k, dall[k], exp_all(k));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_despawn();
        test_exhaustion();
        test_ramp();
        test_freeze();
        test_random();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
